calc_core: RTL and testbench
============================

# calc_core

Parametrised successor to the 4-bit calculator. It holds a register file of NREGS words of WIDTH bits and accepts one instruction at a time over a valid/ready handshake. Each instruction computes regs[src_addr] op immediate and writes the result back to regs[dst_addr]. It adds carry/zero flags, signed SLT and a multi-cycle shift-add multiply, and sits between the instruction source and any consumer of the asynchronous read port.

## Interface
Parameters:
- WIDTH, 4, datapath and register width in bits (≥2).
- NREGS, 4, number of registers; power of two ≥2.
- AW, derived as log2(NREGS), register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  core can accept; equals rst_n && state==IDLE.
- control  in  3  opcode; see Operation.
- src_addr  in  AW  source register.
- dst_addr  in  AW  destination register.
- immediate  in  WIDTH  second operand.
- rd_addr  in  AW  read-port address.
- rd_data  out  WIDTH  combinational regs[rd_addr].
- done  out  1  one-cycle pulse after each writeback.
- carry  out  1  carry flag of last writeback.
- zero  out  1  result==0 flag of last writeback.

## Operation
- Opcodes, with a = regs[src_addr] and b = immediate, both latched at accept:
  - 000: AND, a&b
  - 001: OR, a|b
  - 010: ADD, a+b
  - 011: MUL, low WIDTH bits of a*b (unsigned)
  - 100: AND_NOT, a&~b
  - 101: OR_NOT, a|~b
  - 110: SUB, a+~b+1
  - 111: SLT, {0…0, signed(a)<signed(b)}
- States:
  - IDLE: accepts on in_valid && in_ready.
  - EXEC: single-cycle ops.
  - MUL: iterative multiply.
- Transitions:
  - IDLE→EXEC on accept with opcode ≠011.
  - IDLE→MUL on accept with opcode 011.
  - EXEC→IDLE always.
  - MUL→IDLE when the iteration counter reaches 1.
- MUL datapath: a 2·WIDTH-bit accumulator, multiplicand shifted left and multiplier shifted right each edge. Add when the multiplier LSB is 1. Counter loaded with WIDTH at accept.
- carry flag, per opcode:
  - ADD: carry-out of bit WIDTH-1.
  - SUB: carry-out of a+~b+1, so 1 means no borrow.
  - MUL: 1 if the upper WIDTH product bits are nonzero.
  - All others: 0.
- zero = (written result == 0). Both flags hold until the next writeback.
- Operands are latched at accept, so src_addr==dst_addr is legal and uses the old value.
- in_valid while busy is ignored; there is no queue. The source must hold the instruction until in_ready.
- Writes to any register, including address 0, are permitted; no register is hardwired.

## Timing
- Reset (asynchronous, effective immediately on rst_n low):
  - all registers 0; carry=0; zero=0; done=0; state IDLE.
  - in_ready=0 while rst_n is low.
- Accept edge E0:
  - Non-MUL: writeback and flag update at E1; done=1 for the cycle after E1; in_ready=1 again after E1. Throughput is one op per 2 cycles.
  - MUL: iterations on E1…E_WIDTH; writeback and flags on E_WIDTH; done for the cycle after E_WIDTH. in_ready is 0 from after E0 until after E_WIDTH.
- rd_data reflects a write immediately after the writeback edge, with zero extra latency.
- A new instruction may be accepted on the first edge at which in_ready=1, i.e. the cycle done is high.
- Reset mid-operation aborts the operation: no writeback, no done, flags cleared.

## Test plan
- Reset (WIDTH=4, NREGS=4) → rd_data=0 for rd_addr 0..3, carry=0, zero=0, in_ready=1 after rst_n rises.
- ADD src0 imm 7 dst1 → r1=0111 at E1, done one cycle, carry=0, zero=0. Then SUB src1 imm 7 dst2 → r2=0000, zero=1, carry=1.
- SUB src0 imm 1 dst3 → r3=1111, carry=0. Then SLT src3 imm 0001 dst0 → r0=0001. SLT src1 imm 1000 dst0 → r0=0000, zero=1.
- MUL src1(7) imm 3 dst2 → r2=0101 at E4, carry=1, in_ready low after E0 through E4. MUL src1 imm 2 → 1110, carry=0.
- Assert rst_n low between E2 and E3 of a MUL → no done, all registers 0, state IDLE. Hold in_valid high with a second instruction during a MUL → second instruction accepted only on the done cycle.
- WIDTH=8, NREGS=8: ADD r0+15→r5, then MUL src5 imm 17 dst7 → r7=11111111 at E8, carry=0. OR_NOT src7 imm 0 → 11111111.

Source files
------------

// File: rtl/calc_core.sv
// ============================================================================
// calc_core : register-file calculator, valid/ready instruction port,
//             carry/zero flags, signed SLT and iterative shift-add multiply.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module calc_core #(
    parameter int WIDTH = 4,
    parameter int NREGS = 4,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       control,
    input  logic [AW-1:0]    src_addr,
    input  logic [AW-1:0]    dst_addr,
    input  logic [WIDTH-1:0] immediate,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             done,
    output logic             carry,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [2:0] c_OP_AND  = 3'b000;
    localparam logic [2:0] c_OP_OR   = 3'b001;
    localparam logic [2:0] c_OP_ADD  = 3'b010;
    localparam logic [2:0] c_OP_MUL  = 3'b011;
    localparam logic [2:0] c_OP_ANDN = 3'b100;
    localparam logic [2:0] c_OP_ORN  = 3'b101;
    localparam logic [2:0] c_OP_SUB  = 3'b110;
    localparam logic [WIDTH:0] c_ONE = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [WIDTH-1:0]       r_regs [NREGS];
    logic [2:0]             r_op;
    logic [AW-1:0]          r_dst;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [2*WIDTH-1:0]     r_acc;
    logic [CW-1:0]          r_cnt;
    logic                   r_done;
    logic                   r_carry;
    logic                   r_zero;

    logic                   w_accept;
    logic [WIDTH-1:0]       w_a;
    logic [WIDTH-1:0]       w_b;
    logic [WIDTH-1:0]       w_res;
    logic                   w_cout;
    logic [2*WIDTH-1:0]     w_acc_next;

    // Multiplicand/multiplier registers double as the a/b operand latches for single-cycle ops
    assign w_a      = r_mcand[WIDTH-1:0];
    assign w_b      = r_mplier;
    assign in_ready = rst_n && (r_state == S_IDLE);
    assign w_accept = in_valid && in_ready;
    assign rd_data  = r_regs[rd_addr];
    assign done     = r_done;
    assign carry    = r_carry;
    assign zero     = r_zero;

    always_comb begin
        w_res        = '0;
        w_cout       = 1'b0;
        w_acc_next   = r_acc + (r_mplier[0] ? r_mcand : '0);
        w_next_state = r_state;
        case (r_op)
            c_OP_AND:  w_res = w_a & w_b;
            c_OP_OR:   w_res = w_a | w_b;
            c_OP_ADD:  {w_cout, w_res} = {1'b0, w_a} + {1'b0, w_b};
            c_OP_ANDN: w_res = w_a & ~w_b;
            c_OP_ORN:  w_res = w_a | ~w_b;
            c_OP_SUB:  {w_cout, w_res} = {1'b0, w_a} + {1'b0, ~w_b} + c_ONE;
            c_OP_MUL:  w_res = '0;
            default:   w_res[0] = ($signed(w_a) < $signed(w_b));
        endcase
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = (control == c_OP_MUL) ? S_MUL : S_EXEC;
            S_EXEC: w_next_state = S_IDLE;
            S_MUL:  if (r_cnt == CW'(1)) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_op     <= '0;
            r_dst    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= control;
                        r_dst    <= dst_addr;
                        r_mcand  <= {{WIDTH{1'b0}}, r_regs[src_addr]};
                        r_mplier <= immediate;
                        r_acc    <= '0;
                        r_cnt    <= CW'(WIDTH);
                    end
                end
                S_EXEC: begin
                    r_regs[r_dst] <= w_res;
                    r_carry       <= w_cout;
                    r_zero        <= (w_res == '0);
                    r_done        <= 1'b1;
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CW'(1);
                    // Final iteration: commit the completed product straight from the adder
                    if (r_cnt == CW'(1)) begin
                        r_regs[r_dst] <= w_acc_next[WIDTH-1:0];
                        r_carry       <= |w_acc_next[2*WIDTH-1:WIDTH];
                        r_zero        <= (w_acc_next[WIDTH-1:0] == '0);
                        r_done        <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_calc_core.sv
// ============================================================================
// tb_calc_core : self-checking bench for calc_core at 4x4 and 8x8 geometries.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_calc_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v4 = 1'b0, v8 = 1'b0;
    logic [2:0] control = '0, src = '0, dst = '0, rda = '0;
    logic [7:0] imm = '0;
    logic       sel = 1'b0;

    logic       rdy4, done4, c4, z4;
    logic [3:0] rd4;
    logic       rdy8, done8, c8, z8;
    logic [7:0] rd8;

    logic [7:0] obs_rd;
    logic       obs_rdy, obs_done, obs_c, obs_z;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] mreg [0:1][0:7];
    logic       mc [0:1];
    logic       mz [0:1];

    always #5 clk = ~clk;

    assign obs_rd   = sel ? rd8 : {4'b0, rd4};
    assign obs_rdy  = sel ? rdy8 : rdy4;
    assign obs_done = sel ? done8 : done4;
    assign obs_c    = sel ? c8 : c4;
    assign obs_z    = sel ? z8 : z4;

    calc_core #(.WIDTH(4), .NREGS(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .control(control),
        .src_addr(src[1:0]), .dst_addr(dst[1:0]), .immediate(imm[3:0]), .rd_addr(rda[1:0]),
        .rd_data(rd4), .done(done4), .carry(c4), .zero(z4)
    );

    calc_core #(.WIDTH(8), .NREGS(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .control(control),
        .src_addr(src), .dst_addr(dst), .immediate(imm), .rd_addr(rda),
        .rd_data(rd8), .done(done8), .carry(c8), .zero(z8)
    );

    // Reference arithmetic straight from the opcode definitions
    function automatic void ref_op(input int w, input logic [2:0] op, input logic [7:0] a,
                                   input logic [7:0] b, output logic [7:0] r, output logic c);
        longint m, x, y, f, sx, sy;
        m = (longint'(1) << w) - 1;
        x = longint'(a) & m;
        y = longint'(b) & m;
        c = 1'b0;
        f = 0;
        case (op)
            3'd0: f = x & y;
            3'd1: f = x | y;
            3'd2: begin f = x + y; c = ((f >> w) & 1) != 0; end
            3'd3: begin f = x * y; c = (f >> w) != 0; end
            3'd4: f = x & ~y;
            3'd5: f = x | (~y & m);
            3'd6: begin f = x + (~y & m) + 1; c = ((f >> w) & 1) != 0; end
            default: begin
                sx = (x >= (longint'(1) << (w - 1))) ? x - (longint'(1) << w) : x;
                sy = (y >= (longint'(1) << (w - 1))) ? y - (longint'(1) << w) : y;
                f = (sx < sy) ? 1 : 0;
            end
        endcase
        r = 8'(f & m);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) mreg[k][i] = '0;
            mc[k] = 1'b0;
            mz[k] = 1'b0;
        end
    endfunction

    // Drives one instruction, updates the model, returns at the negedge where done is high
    task automatic issue(input logic w8, input logic [2:0] op, input logic [2:0] s,
                         input logic [2:0] d, input logic [7:0] b,
                         output int lat, output logic busy_err, output logic to);
        int n;
        logic [7:0] r;
        logic c;
        if (!w8) begin s = s & 3'd3; d = d & 3'd3; b = b & 8'h0F; end
        sel = w8;
        @(negedge clk);
        control = op; src = s; dst = d; imm = b;
        if (w8) v8 = 1'b1; else v4 = 1'b1;
        n = 0;
        while (!obs_rdy && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        v4 = 1'b0; v8 = 1'b0;
        ref_op(w8 ? 8 : 4, op, mreg[w8][s], b, r, c);
        mreg[w8][d] = r; mc[w8] = c; mz[w8] = (r == 8'h00);
        busy_err = 1'b0;
        @(negedge clk);
        lat = 0;
        while (!obs_done && lat < 100) begin
            if (obs_rdy) busy_err = 1'b1;
            @(negedge clk);
            lat++;
        end
        to = (lat >= 100) || (n >= 100);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; v4 = 1'b0; v8 = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (rdy4 !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b want 0", rdy4); end
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            rda = 3'(i); #1;
            n_cmp++; if (rd4 !== 4'h0) begin n_fail++; $display("FAIL reset_reg4[%0d]: got %h want 0", i, rd4); end
        end
        n_cmp++; if ({c4, z4, done4} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got c=%b z=%b d=%b want 000", c4, z4, done4); end
        n_cmp++; if ({rdy4, rdy8} !== 2'b11) begin n_fail++; $display("FAIL reset_ready_high: got %b%b want 11", rdy4, rdy8); end
        model_reset();
    endtask

    task automatic test_directed4();
        int lat; logic be, to;
        logic [7:0] exp_r [7] = '{8'h07, 8'h00, 8'h0F, 8'h01, 8'h00, 8'h05, 8'h0E};
        logic       exp_c [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_z [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0] ops   [7] = '{3'd2, 3'd6, 3'd6, 3'd7, 3'd7, 3'd3, 3'd3};
        logic [2:0] srcs  [7] = '{3'd0, 3'd1, 3'd0, 3'd3, 3'd1, 3'd1, 3'd1};
        logic [2:0] dsts  [7] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd2, 3'd3};
        logic [7:0] imms  [7] = '{8'h07, 8'h07, 8'h01, 8'h01, 8'h08, 8'h03, 8'h02};
        for (int i = 0; i < 7; i++) begin
            issue(1'b0, ops[i], srcs[i], dsts[i], imms[i], lat, be, to);
            rda = dsts[i]; #1;
            n_cmp++; if (obs_rd !== exp_r[i]) begin n_fail++; $display("FAIL dir4_result[%0d]: got %h want %h", i, obs_rd, exp_r[i]); end
            n_cmp++; if ({obs_c, obs_z} !== {exp_c[i], exp_z[i]}) begin n_fail++; $display("FAIL dir4_flags[%0d]: got cz=%b%b want %b%b", i, obs_c, obs_z, exp_c[i], exp_z[i]); end
            n_cmp++; if (lat !== ((ops[i] == 3'd3) ? 4 : 1) || be !== 1'b0 || to !== 1'b0) begin n_fail++; $display("FAIL dir4_timing[%0d]: got lat=%0d busy_err=%b to=%b want lat=%0d", i, lat, be, to, (ops[i] == 3'd3) ? 4 : 1); end
            @(negedge clk);
            n_cmp++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL dir4_done_pulse[%0d]: got %b want 0", i, done4); end
        end
    endtask

    task automatic test_w8();
        int lat; logic be, to;
        issue(1'b1, 3'd2, 3'd0, 3'd5, 8'd15, lat, be, to);
        rda = 3'd5; #1;
        n_cmp++; if (rd8 !== 8'h0F || lat !== 1) begin n_fail++; $display("FAIL w8_add: got %h lat=%0d want 0f lat=1", rd8, lat); end
        issue(1'b1, 3'd3, 3'd5, 3'd7, 8'd17, lat, be, to);
        rda = 3'd7; #1;
        n_cmp++; if (rd8 !== 8'hFF || c8 !== 1'b0) begin n_fail++; $display("FAIL w8_mul: got %h c=%b want ff c=0", rd8, c8); end
        n_cmp++; if (lat !== 8 || be !== 1'b0 || to !== 1'b0) begin n_fail++; $display("FAIL w8_mul_timing: got lat=%0d busy_err=%b to=%b want lat=8", lat, be, to); end
        issue(1'b1, 3'd5, 3'd7, 3'd6, 8'd0, lat, be, to);
        rda = 3'd6; #1;
        n_cmp++; if (rd8 !== 8'hFF || {c8, z8} !== 2'b00) begin n_fail++; $display("FAIL w8_or_not: got %h cz=%b%b want ff 00", rd8, c8, z8); end
    endtask

    task automatic test_back_to_back();
        int n; logic early;
        logic [7:0] r; logic c;
        sel = 1'b0;
        @(negedge clk);
        control = 3'd3; src = 3'd1; dst = 3'd2; imm = 8'h05; v4 = 1'b1;
        n = 0;
        while (!rdy4 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        ref_op(4, 3'd3, mreg[0][1], 8'h05, r, c);
        mreg[0][2] = r; mc[0] = c; mz[0] = (r == 8'h00);
        control = 3'd2; src = 3'd2; dst = 3'd3; imm = 8'h09;
        early = 1'b0;
        @(negedge clk);
        n = 0;
        while (!done4 && n < 20) begin
            if (rdy4) early = 1'b1;
            @(negedge clk);
            n++;
        end
        n_cmp++; if (early !== 1'b0 || n !== 4) begin n_fail++; $display("FAIL b2b_hold: got early=%b lat=%0d want early=0 lat=4", early, n); end
        n_cmp++; if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_on_done: got %b want 1", rdy4); end
        rda = 3'd2; #1;
        n_cmp++; if ({4'b0, rd4} !== mreg[0][2]) begin n_fail++; $display("FAIL b2b_mul_result: got %h want %h", rd4, mreg[0][2]); end
        ref_op(4, 3'd2, mreg[0][2], 8'h09, r, c);
        mreg[0][3] = r; mc[0] = c; mz[0] = (r == 8'h00);
        @(posedge clk);
        #1;
        v4 = 1'b0;
        @(negedge clk);
        n_cmp++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got done=%b want 0", done4); end
        @(negedge clk);
        rda = 3'd3; #1;
        n_cmp++; if (done4 !== 1'b1 || {4'b0, rd4} !== mreg[0][3] || c4 !== mc[0]) begin n_fail++; $display("FAIL b2b_second: got done=%b r=%h c=%b want 1 %h %b", done4, rd4, c4, mreg[0][3], mc[0]); end
    endtask

    task automatic test_random();
        int lat; logic be, to;
        logic w8; logic [2:0] op, s, d, o;
        for (int i = 0; i < 60; i++) begin
            w8 = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            s  = 3'($urandom_range(0, 7));
            d  = 3'($urandom_range(0, 7));
            if (!w8) begin s = s & 3'd3; d = d & 3'd3; end
            issue(w8, op, s, d, 8'($urandom), lat, be, to);
            rda = d; #1;
            n_cmp++; if (obs_rd !== mreg[w8][d]) begin n_fail++; $display("FAIL rand_result[%0d]: w8=%b op=%0d got %h want %h", i, w8, op, obs_rd, mreg[w8][d]); end
            n_cmp++; if ({obs_c, obs_z} !== {mc[w8], mz[w8]}) begin n_fail++; $display("FAIL rand_flags[%0d]: w8=%b op=%0d got cz=%b%b want %b%b", i, w8, op, obs_c, obs_z, mc[w8], mz[w8]); end
            n_cmp++; if (lat !== ((op == 3'd3) ? (w8 ? 8 : 4) : 1) || be !== 1'b0 || to !== 1'b0) begin n_fail++; $display("FAIL rand_timing[%0d]: got lat=%0d busy_err=%b to=%b", i, lat, be, to); end
            o = 3'($urandom_range(0, w8 ? 7 : 3));
            rda = o; #1;
            n_cmp++; if (obs_rd !== mreg[w8][o]) begin n_fail++; $display("FAIL rand_other[%0d]: reg %0d got %h want %h", i, o, obs_rd, mreg[w8][o]); end
        end
    endtask

    task automatic test_mul_reset();
        int n, lat; logic be, to, seen;
        issue(1'b0, 3'd1, 3'd0, 3'd1, 8'h09, lat, be, to);
        @(negedge clk);
        control = 3'd3; src = 3'd1; dst = 3'd2; imm = 8'h0B; v4 = 1'b1;
        n = 0;
        while (!rdy4 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        v4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({rdy4, done4, c4, z4} !== 4'b0000) begin n_fail++; $display("FAIL mrst_outputs: got rdy=%b done=%b c=%b z=%b want 0000", rdy4, done4, c4, z4); end
        for (int i = 0; i < 4; i++) begin
            rda = 3'(i); #1;
            n_cmp++; if (rd4 !== 4'h0) begin n_fail++; $display("FAIL mrst_reg[%0d]: got %h want 0", i, rd4); end
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); if (done4) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0 || rdy4 !== 1'b1) begin n_fail++; $display("FAIL mrst_abort: got done_seen=%b rdy=%b want 0 1", seen, rdy4); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_directed4();
        test_w8();
        test_back_to_back();
        test_random();
        test_mul_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
